// File: rtl/meteor_spawn_rng.sv
// meteor_spawn_rng: per-slot spawn parameter generator for falling objects.
// A free-running 16-bit Galois LFSR is shared by NUM_OBJ request channels.
// A round-robin arbiter picks one pending slot at a time.
// Each issue returns an in-range x position, x/y speeds and the slot id.
// Ports:
//   Clk, Reset       clock, synchronous active-high reset
//   spawn_req        per-slot request (level or pulse), sampled every edge
//   reseed, seed_in  load a new LFSR seed (a zero seed maps to SEED)
//   spawn_valid      one-cycle pulse when spawn_id/x/xs/ys are new
//   spawn_id         slot being served
//   spawn_x          x position, 0..X_MAX-1
//   spawn_xs/ys      speeds, SPD_MIN..2^SPD_W-1
//   busy             high while a draw is in progress
module meteor_spawn_rng #(
   parameter int          NUM_OBJ   = 4,
   parameter int          X_W       = 10,
   parameter int          X_MAX     = 640,
   parameter int          SPD_W     = 4,
   parameter int          SPD_MIN   = 1,
   parameter int          MAX_TRIES = 4,
   parameter logic [15:0] SEED      = 16'hACE1,
   localparam int         ID_W      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [NUM_OBJ-1:0] spawn_req,
   input  logic               reseed,
   input  logic [15:0]        seed_in,
   output logic               spawn_valid,
   output logic [ID_W-1:0]    spawn_id,
   output logic [X_W-1:0]     spawn_x,
   output logic [SPD_W-1:0]   spawn_xs,
   output logic [SPD_W-1:0]   spawn_ys,
   output logic               busy
);

   localparam int               TR_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [X_W:0]     XMAX_C = (X_W+1)'(X_MAX);
   localparam logic [NUM_OBJ-1:0] ONE  = NUM_OBJ'(1);
   localparam logic [SPD_W-1:0] SMIN_C = SPD_W'(SPD_MIN);

   typedef enum logic {
      S_IDLE,
      S_DRAW
   } state_t;

   state_t             r_state;
   logic [15:0]        r_lfsr;
   logic [NUM_OBJ-1:0] r_pending;
   logic [ID_W-1:0]    r_last;
   logic [ID_W-1:0]    r_cur;
   logic [TR_W-1:0]    r_tries;

   logic               w_gnt_found;
   logic [ID_W-1:0]    w_gnt_id;
   logic [X_W-1:0]     w_xr;
   logic               w_in_rng;
   logic               w_last_try;
   logic               w_accept;
   logic [X_W-1:0]     w_x;
   logic [SPD_W-1:0]   w_xs_raw;
   logic [SPD_W-1:0]   w_ys_raw;
   logic [NUM_OBJ-1:0] w_clr;
   logic [15:0]        w_lfsr_nxt;
   logic [15:0]        w_seed;

   // Round-robin search: first pending slot after the last one served.
   always_comb begin
      int idx;
      idx         = 0;
      w_gnt_found = 1'b0;
      w_gnt_id    = '0;
      for (int k = 1; k <= NUM_OBJ; k++) begin
         idx = (int'(r_last) + k) % NUM_OBJ;
         if (!w_gnt_found && r_pending[idx]) begin
            w_gnt_found = 1'b1;
            w_gnt_id    = ID_W'(idx);
         end
      end
   end

   // Rejection sampling; the final attempt folds out-of-range values down.
   assign w_xr       = r_lfsr[X_W-1:0];
   assign w_in_rng   = ({1'b0, w_xr} < XMAX_C);
   assign w_last_try = (r_tries == TR_W'(MAX_TRIES-1));
   assign w_accept   = (r_state == S_DRAW) && (w_in_rng || w_last_try);
   assign w_x        = w_in_rng ? w_xr : X_W'({1'b0, w_xr} - XMAX_C);
   assign w_xs_raw   = r_lfsr[X_W+SPD_W-1:X_W];
   assign w_ys_raw   = r_lfsr[15:16-SPD_W] ^ r_lfsr[SPD_W-1:0];
   assign w_clr      = w_accept ? (ONE << r_cur) : '0;

   assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   // A zero seed would lock the LFSR, so it is replaced by the reset seed.
   assign w_seed     = (seed_in == 16'h0000) ? SEED : seed_in;

   assign busy = (r_state == S_DRAW);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_lfsr    <= SEED;
         r_pending <= '0;
      end else begin
         r_lfsr    <= reseed ? w_seed : w_lfsr_nxt;
         // A request on the issue edge re-arms the slot just served.
         r_pending <= (r_pending & ~w_clr) | spawn_req;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_last      <= ID_W'(NUM_OBJ-1);
         r_cur       <= '0;
         r_tries     <= '0;
         spawn_valid <= 1'b0;
         spawn_id    <= '0;
         spawn_x     <= '0;
         spawn_xs    <= '0;
         spawn_ys    <= '0;
      end else begin
         spawn_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_gnt_found) begin
                  r_cur   <= w_gnt_id;
                  r_tries <= '0;
                  r_state <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (w_accept) begin
                  spawn_valid <= 1'b1;
                  spawn_id    <= r_cur;
                  spawn_x     <= w_x;
                  spawn_xs    <= (w_xs_raw == '0) ? SMIN_C : w_xs_raw;
                  spawn_ys    <= (w_ys_raw == '0) ? SMIN_C : w_ys_raw;
                  r_last      <= r_cur;
                  r_state     <= S_IDLE;
               end else begin
                  r_tries <= r_tries + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_meteor_spawn_rng.sv
// tb_meteor_spawn_rng: directed and randomized checks of meteor_spawn_rng
// against a cycle-level behavioural model of the spawn rules.
module tb_meteor_spawn_rng;

   localparam int N    = 4;
   localparam int XMAX = 640;
   localparam int MT   = 4;
   localparam int SEED = 16'hACE1;

   logic         Clk;
   logic         Reset;
   logic [3:0]   spawn_req;
   logic         reseed;
   logic [15:0]  seed_in;

   logic         spawn_valid;
   logic [1:0]   spawn_id;
   logic [9:0]   spawn_x;
   logic [3:0]   spawn_xs;
   logic [3:0]   spawn_ys;
   logic         busy;

   logic         f_valid;
   logic [1:0]   f_id;
   logic [9:0]   f_x;
   logic [3:0]   f_xs;
   logic [3:0]   f_ys;
   logic         f_busy;

   int n_tests = 0;
   int n_fail  = 0;

   meteor_spawn_rng dut (
      .Clk(Clk), .Reset(Reset), .spawn_req(spawn_req),
      .reseed(reseed), .seed_in(seed_in),
      .spawn_valid(spawn_valid), .spawn_id(spawn_id),
      .spawn_x(spawn_x), .spawn_xs(spawn_xs), .spawn_ys(spawn_ys),
      .busy(busy)
   );

   meteor_spawn_rng #(.MAX_TRIES(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .spawn_req(spawn_req),
      .reseed(reseed), .seed_in(seed_in),
      .spawn_valid(f_valid), .spawn_id(f_id),
      .spawn_x(f_x), .spawn_xs(f_xs), .spawn_ys(f_ys),
      .busy(f_busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Behavioural model state (plain integers).
   int m_lfsr, m_last, m_cur, m_tries;
   int m_id, m_x, m_xs, m_ys;
   bit m_valid, m_draw;
   bit m_pend [N];

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int lfsr_next(input int l);
      return (l >> 1) ^ (((l & 1) != 0) ? 16'hB400 : 0);
   endfunction

   function automatic int fix_spd(input int s);
      return (s == 0) ? 1 : s;
   endfunction

   task automatic model_edge();
      int xr, idx;
      bit any, found;
      int clr;
      if (Reset) begin
         m_lfsr = SEED; m_draw = 0; m_last = N-1; m_tries = 0; m_cur = 0;
         m_valid = 0; m_id = 0; m_x = 0; m_xs = 0; m_ys = 0;
         foreach (m_pend[i]) m_pend[i] = 0;
         return;
      end
      m_valid = 0;
      clr = -1;
      if (!m_draw) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && m_pend[idx]) begin
               found = 1; m_cur = idx;
            end
         end
         if (found) begin
            m_tries = 0; m_draw = 1;
         end
      end else begin
         xr = m_lfsr % 1024;
         if (xr < XMAX || m_tries == MT-1) begin
            m_x = (xr >= XMAX) ? xr - XMAX : xr;
            m_xs = fix_spd((m_lfsr / 1024) % 16);
            m_ys = fix_spd(((m_lfsr / 4096) ^ m_lfsr) % 16);
            m_id = m_cur; m_valid = 1; m_last = m_cur;
            clr = m_cur; m_draw = 0;
         end else begin
            m_tries++;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (i == clr) m_pend[i] = 0;
         if (spawn_req[i]) m_pend[i] = 1;
      end
      any = 0;
      if (reseed) m_lfsr = (seed_in == 0) ? SEED : int'(seed_in);
      else        m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic step();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      check("valid", spawn_valid, m_valid);
      check("busy", busy, m_draw);
      check("id", spawn_id, m_id);
      check("x", spawn_x, m_x);
      check("xs", spawn_xs, m_xs);
      check("ys", spawn_ys, m_ys);
      if (spawn_valid) begin
         check("x_range", int'(spawn_x < XMAX), 1);
         check("xs_min", int'(spawn_xs >= 1), 1);
         check("ys_min", int'(spawn_ys >= 1), 1);
      end
   endtask

   task automatic wait_valid(input int max_cyc, input string tag);
      int n;
      n = 0;
      while (!spawn_valid && n < max_cyc) begin
         step();
         n++;
      end
      if (!spawn_valid) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic idle_cycles(input int n);
      spawn_req = '0; reseed = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int k, prev;
      Reset = 1; spawn_req = 4'hF; reseed = 0; seed_in = '0;

      // Reset held with requests active
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_valid", spawn_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_x", spawn_x, 0);
      end

      // Round robin with all slots requesting
      Reset = 0;
      prev = -1;
      for (k = 0; k < 16; k++) begin
         step();
         wait_valid(20, "rr");
         check("rr_id", spawn_id, k % N);
         check("rr_no_repeat", int'(int'(spawn_id) != prev), 1);
         prev = spawn_id;
      end
      step();
      check("rr_pulse", spawn_valid, 0);
      idle_cycles(20);

      // Single request with reseed on the same edge
      reseed = 1; seed_in = 16'hACE1; spawn_req = 4'b0100;
      step();
      reseed = 0; spawn_req = '0;
      step();
      check("single_early", spawn_valid, 0);
      step();
      check("single_valid", spawn_valid, 1);
      check("single_id", spawn_id, 2);
      check("single_x", spawn_x, 624);
      check("single_xs", spawn_xs, 8);
      check("single_ys", spawn_ys, 14);
      step();
      check("single_pulse", spawn_valid, 0);
      check("single_hold_x", spawn_x, 624);
      idle_cycles(4);

      // Rejection then accept, zero speed forced to minimum
      reseed = 1; seed_in = 16'h6FFF; spawn_req = 4'b0001;
      step();
      reseed = 0; spawn_req = '0;
      step();
      step();
      check("rej_not_yet", spawn_valid, 0);
      check("rej_busy", busy, 1);
      step();
      check("rej_valid", spawn_valid, 1);
      check("rej_id", spawn_id, 0);
      check("rej_x", spawn_x, 511);
      check("rej_xs", spawn_xs, 13);
      check("rej_ys", spawn_ys, 1);
      idle_cycles(4);

      // Zero seed maps to the reset seed
      reseed = 1; seed_in = 16'h0000; spawn_req = 4'b0010;
      step();
      reseed = 0; spawn_req = '0;
      step();
      step();
      check("zseed_valid", spawn_valid, 1);
      check("zseed_id", spawn_id, 1);
      check("zseed_x", spawn_x, 624);
      check("zseed_ys", spawn_ys, 14);
      idle_cycles(4);

      // Request on the slot's own issue edge re-arms it
      reseed = 1; seed_in = 16'hACE1; spawn_req = 4'b1000;
      step();
      reseed = 0; spawn_req = '0;
      step();
      spawn_req = 4'b1000;
      step();
      check("rearm_first", spawn_valid, 1);
      check("rearm_first_id", spawn_id, 3);
      spawn_req = '0;
      step();
      wait_valid(20, "rearm");
      check("rearm_second_id", spawn_id, 3);
      idle_cycles(6);

      // Reset in the middle of a draw
      reseed = 1; seed_in = 16'h6FFF; spawn_req = 4'b0001;
      step();
      reseed = 0; spawn_req = '0;
      step();
      check("abort_busy_before", busy, 1);
      Reset = 1;
      step();
      Reset = 0;
      check("abort_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("abort_no_valid", spawn_valid, 0);
      end

      // Fold fallback on a single-try instance
      reseed = 1; seed_in = 16'h6FFF; spawn_req = 4'b0001;
      step();
      reseed = 0; spawn_req = '0;
      step();
      step();
      check("fold_valid", f_valid, 1);
      check("fold_id", f_id, 0);
      check("fold_x", f_x, 383);
      check("fold_xs", f_xs, 1);
      check("fold_ys", f_ys, 7);
      idle_cycles(4);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         Reset     = ($urandom_range(0, 299) == 0);
         spawn_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         reseed    = ($urandom_range(0, 49) == 0);
         seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/meteor_spawn_rng.md
Name: meteor_spawn_rng

Overview:
- Multi-channel spawn-parameter generator for falling objects. It is the successor of the single-counter x-position generator.
- A free-running 16-bit Galois LFSR feeds a round-robin arbiter that serves spawn requests from NUM_OBJ object slots.
- For each request it returns an in-range x position, x/y speeds and the slot id.
- It sits between the object-slot controllers, which request when a slot dies or leaves the screen, and the object position registers.

Parameters:
- NUM_OBJ, 4: number of object slots / request channels.
- X_W, 10: width of x position output.
- X_MAX, 640: exclusive upper bound of x. Constraint: X_MAX <= 2^X_W and 2^X_W - X_MAX < X_MAX.
- SPD_W, 4: width of each speed output. Constraint: X_W + SPD_W <= 16.
- SPD_MIN, 1: value substituted when a drawn speed is 0.
- MAX_TRIES, 4: rejection-sampling attempts before the fold fallback (>= 1).
- SEED, 16'hACE1: reset value of the LFSR, also used when a zero seed is supplied.

Ports:
- Clk, in, 1: clock.
- Reset, in, 1: synchronous, active-high reset.
- spawn_req, in, NUM_OBJ: level/pulse request per slot. Sampled every edge.
- reseed, in, 1: load seed_in into the LFSR at the next edge.
- seed_in, in, 16: new LFSR seed.
- spawn_valid, out, 1: one-cycle pulse; the outputs below are valid.
- spawn_id, out, clog2(NUM_OBJ) (min 1): slot being served.
- spawn_x, out, X_W: new x position, 0..X_MAX-1.
- spawn_xs, out, SPD_W: new x speed, SPD_MIN..2^SPD_W-1.
- spawn_ys, out, SPD_W: new y speed, SPD_MIN..2^SPD_W-1.
- busy, out, 1: high while in DRAW.

Behaviour:
- Reset (synchronous, wins over everything):
  - lfsr=SEED, pending=0, state=IDLE, last_grant=NUM_OBJ-1, tries=0.
  - All outputs 0.
- LFSR: advances every non-reset cycle.
  - lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
  - reseed overrides the advance: lfsr <= (seed_in==0) ? SEED : seed_in. This is legal in any state, including mid-DRAW.
  - The LFSR never holds 0.
- Pending register: pending <= (pending & ~clr) | spawn_req.
  - clr is the one-hot of the slot issued on this edge.
  - A request arriving on its own issue edge re-arms the slot.
  - Duplicate requests while pending are absorbed (one issue only).
- FSM IDLE:
  - If pending != 0: grant the first set bit searching from last_grant+1 upward with wrap.
  - Store it in cur_id, set tries=0, go to DRAW. Otherwise stay in IDLE.
- FSM DRAW: examine the current lfsr each cycle.
  - Let xr = lfsr[X_W-1:0].
  - Accept if xr < X_MAX, or if tries == MAX_TRIES-1. In the second case x = (xr >= X_MAX) ? xr - X_MAX : xr (fold).
  - Otherwise tries++ and stay in DRAW. The next cycle sees the next LFSR value.
  - On accept, at that edge:
    - spawn_x = x.
    - xs = lfsr[X_W+SPD_W-1:X_W].
    - ys = lfsr[15:16-SPD_W] ^ lfsr[SPD_W-1:0].
    - Either speed that is 0 is replaced by SPD_MIN.
    - spawn_id = cur_id, spawn_valid = 1 for exactly the following cycle, last_grant = cur_id, pending[cur_id] cleared, state = IDLE.
- Output holding: spawn_x/xs/ys/id hold their last values between issues. spawn_valid is 0 except for the issue cycle.
- Latency:
  - Request sampled at edge t: IDLE grants at edge t+1; DRAW accepts at earliest at edge t+2; spawn_valid is high in the cycle after edge t+2.
  - Worst case is t+1+MAX_TRIES.
  - Back-to-back issues are at best every 2 cycles (DRAW, IDLE).
- Fairness: with all slots continuously requesting, slots are served cyclically 0,1,2,3,0,… after reset.
- Reset during DRAW aborts the draw: no spawn_valid, pending lost.

Test Plan:
- Reset check: assert Reset 3 cycles with spawn_req=4'hF -> spawn_valid=0, busy=0, outputs 0, pending empty; first grant after release is id 0.
- Single request: reseed seed_in=16'hACE1 and spawn_req=4'b0100 for one cycle on the same edge -> DRAW sees 16'hE270 -> spawn_valid one cycle with id=2, x=624, xs=8, ys=14, 3 edges after the request.
- Rejection and zero-speed: reseed 16'h6FFF with spawn_req[0]. The first draw, 16'h83FF (x=1023), is rejected; the second draw, 16'hF5FF, is accepted -> id=0, x=511, xs=13, ys=1 (0 forced to SPD_MIN); one extra cycle of latency.
- Fold fallback: with MAX_TRIES=1, reseed 16'h6FFF with a request -> x=1023-640=383 on the first draw, no retry.
- Round robin: spawn_req=4'hF held for 16 issues -> ids 0,1,2,3 repeating; each spawn_valid is 1 cycle; no slot is served twice in a row while others are pending.
- Corner events:
  - reseed with seed_in=0 -> lfsr becomes 16'hACE1.
  - A request on a slot's own issue edge -> that slot is re-served later.
  - Reset mid-DRAW -> no spawn_valid; state returns to IDLE.
